// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU op codes and major opcodes used by the
// operand stage and the ALU.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_e         alu_ctrl;
        logic [4:0]      rd;
        logic            illegal;
    } operand_t;

    function automatic logic [XLEN-1:0] sext12(input logic signed [11:0] imm);
        logic signed [XLEN-1:0] ext;
        ext = XLEN'(imm);
        return ext;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two asynchronous read ports and one write port;
// x0 always reads zero and ignores writes.
module regfile #(
    parameter bit CLEAR_RF = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] mem_q [32];
    logic        wr_en;

    assign wr_en = we_i && (wa_i != 5'd0);

    generate
        if (CLEAR_RF) begin : g_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) mem_q[i] <= '0;
                end else if (wr_en) begin
                    mem_q[wa_i] <= wd_i;
                end
            end
        end else begin : g_noclear
            always_ff @(posedge clk) begin
                if (wr_en) mem_q[wa_i] <= wd_i;
            end
        end
    endgenerate

    // Entry 0 may hold anything; the read mux hides it.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : mem_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : mem_q[ra2_i];

endmodule

// File: rtl/operand_stage.sv
// RV32I operand stage: decodes OP/OP_IMM, reads operands with write-back
// bypass, and presents them to the ALU through a one-entry valid/ready stage.
module operand_stage
    import rv32i_pkg::*;
#(
    parameter bit CLEAR_RF = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        accept;

    operand_t    dec;
    operand_t    out_d, out_q;
    logic        vld_d, vld_q;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    regfile #(.CLEAR_RF(CLEAR_RF)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (wb_en),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    // A write landing in the accept cycle has not reached the array yet.
    assign rs1_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_rd1;
    assign rs2_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_rd2;

    always_comb begin
        logic    legal;
        logic    use_imm;
        alu_op_e op;

        legal   = 1'b0;
        use_imm = 1'b0;
        op      = ALU_ADD;
        dec     = '0;

        case (opcode)
            OP: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            legal = 1'b1; op = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            legal = 1'b1; op = ALU_SUB;
                        end
                    end
                    3'b111: begin legal = (funct7 == 7'd0); op = ALU_AND; end
                    3'b110: begin legal = (funct7 == 7'd0); op = ALU_OR;  end
                    3'b100: begin legal = (funct7 == 7'd0); op = ALU_XOR; end
                    3'b010: begin legal = (funct7 == 7'd0); op = ALU_SLT; end
                    3'b001: begin legal = (funct7 == 7'd0); op = ALU_SLL; end
                    3'b101: begin legal = (funct7 == 7'd0); op = ALU_SRL; end
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                use_imm = 1'b1;
                case (funct3)
                    3'b000: begin legal = 1'b1; op = ALU_ADD; end
                    3'b111: begin legal = 1'b1; op = ALU_AND; end
                    3'b110: begin legal = 1'b1; op = ALU_OR;  end
                    3'b100: begin legal = 1'b1; op = ALU_XOR; end
                    3'b010: begin legal = 1'b1; op = ALU_SLT; end
                    3'b001: begin legal = (funct7 == 7'd0); op = ALU_SLL; end
                    3'b101: begin legal = (funct7 == 7'd0); op = ALU_SRL; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec.a        = rs1_val;
            dec.b        = use_imm ? sext12(instr[31:20]) : rs2_val;
            dec.alu_ctrl = op;
            dec.rd       = instr[11:7];
        end else begin
            dec.illegal  = 1'b1;
        end
    end

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_d = vld_q;
        out_d = out_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (accept) begin
            vld_d = 1'b1;
            out_d = dec;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // Output register stage toward the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            out_q <= '0;
        end else begin
            vld_q <= vld_d;
            out_q <= out_d;
        end
    end

    assign out_valid = vld_q;
    assign A         = out_q.a;
    assign B         = out_q.b;
    assign alu_ctrl  = out_q.alu_ctrl;
    assign rd        = out_q.rd;
    assign illegal   = out_q.illegal;

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter CLEAR_RF, default 0: 1 = register file zeroed by reset; 0 = register file not reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  instr holds an instruction.
REQ-005 SHALL have port in_ready  out  1  stage accepts instr this cycle.
REQ-006 SHALL have port instr  in  32  RV32I instruction word.
REQ-007 SHALL have port wb_en  in  1  register write enable.
REQ-008 SHALL have port wb_rd  in  5  write register index.
REQ-009 SHALL have port wb_data  in  32  write data.
REQ-010 SHALL have port flush  in  1  discard held output.
REQ-011 SHALL have port out_valid  out  1  A/B/alu_ctrl/rd/illegal valid for ALU.
REQ-012 SHALL have port out_ready  in  1  downstream consumes output.
REQ-013 SHALL have ports A, B  out  32 each  registered ALU operands.
REQ-014 SHALL have port alu_ctrl  out  4  registered ALU op code.
REQ-015 SHALL have port rd  out  5  destination register.
REQ-016 SHALL have port illegal  out  1  instruction not supported.

Function
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
REQ-018 SHALL, on accept without flush, register decoded outputs and set out_valid next edge; latency 1 cycle.
REQ-019 SHALL, on out_valid && out_ready && !accept, clear out_valid; outputs otherwise hold while out_valid && !out_ready.
REQ-020 SHALL give flush priority: out_valid=0 next edge, same-cycle accept discarded; register file writes still occur.
REQ-021 SHALL decode opcode 0110011: funct3/funct7 000/0000000 ADD=0, 000/0100000 SUB=1, 111 AND=2, 110 OR=3, 100 XOR=4, 010 SLT=5, 001/0000000 SLL=6, 101/0000000 SRL=7 (funct7 must be 0000000 except SUB); A=rs1 value, B=rs2 value.
REQ-022 SHALL decode opcode 0010011: ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI (slli/srli require instr[31:25]=0); A=rs1 value, B=sign-extended instr[31:20].
REQ-023 SHALL flag anything else (SLTU, SLTIU, SRA, SRAI, other opcodes/funct7) illegal=1 with A=0, B=0, alu_ctrl=ADD, rd=0; still handshaken like a normal instruction.
REQ-024 SHALL write rd = instr[11:7] for legal instructions.
REQ-025 SHALL hold a 32x32 register file, 2 read / 1 write; x0 reads 0, writes to x0 ignored.
REQ-026 SHALL bypass: when wb_en and nonzero wb_rd equals rs1/rs2 in the accept cycle, use wb_data for that operand.
REQ-027 SHALL perform register writes every cycle wb_en=1, independent of handshake state.

Reset
REQ-028 SHALL on rst_n=0 immediately force out_valid=0, A=0, B=0, alu_ctrl=0, rd=0, illegal=0; in_ready therefore 1.
REQ-029 SHALL zero registers x1..x31 on reset only when CLEAR_RF=1.
REQ-030 SHALL discard any held output when reset asserts mid-transfer; no output resumes after release.

Structure
REQ-031 SHALL take ALU op codes (ADD..SRL, 4 bits) and opcode constants OP, OP_IMM from shared package rv32i_pkg, also used by the ALU.
REQ-032 SHALL instantiate one sub-module regfile (2R1W, x0 hardwired, CLEAR_RF pass-through); decode and handshake stay in operand_stage.

Verification
REQ-033 SHALL test: write x1=5, x2=3; accept SUB x3,x1,x2 -> next cycle out_valid=1, A=5, B=3, alu_ctrl=1, rd=3.
REQ-034 SHALL test: ADDI x4,x1,-1 (imm 0xFFF) -> B=0xFFFFFFFF, alu_ctrl=0, rd=4.
REQ-035 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next instruction accepted same cycle.
REQ-036 SHALL test: wb_en=1, wb_rd=1, wb_data=0xA5 in same cycle as accept of AND x5,x1,x1 -> A=B=0xA5; wb_rd=0 -> x0 remains 0.
REQ-037 SHALL test: SRA and SLTIU -> illegal=1, A=B=0, alu_ctrl=0, rd=0.
REQ-038 SHALL test: flush together with accept -> out_valid=0 next cycle; rst_n low while out_valid=1 -> all outputs 0 immediately.
